// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad poll scheduler:
// button indices, FSM states and default timing.
package gamepad_pkg;

    localparam int BTN_W = 12;
    localparam int BTN_A = 0;
    localparam int BTN_B = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP = 4;
    localparam int BTN_DOWN = 5;
    localparam int BTN_LEFT = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_Y = 8;
    localparam int BTN_X = 9;
    localparam int BTN_L = 10;
    localparam int BTN_R = 11;

    localparam int RAW_W = 16;

    localparam int HALF_BIT_DEF = 150;
    localparam int LATCH_CYC_DEF = 300;
    localparam int POLL_PERIOD_DEF = 833333;
    localparam int TMR_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/gamepad_poll_scheduler_if.sv
// Snapshot bus between the poll scheduler and the game logic:
// button state, edge pulses, presence and the valid/ack handshake.
interface gamepad_poll_scheduler_if;
    import gamepad_pkg::*;

    logic [BTN_W-1:0] p1_buttons;
    logic [BTN_W-1:0] p2_buttons;
    logic [BTN_W-1:0] p1_pressed;
    logic [BTN_W-1:0] p2_pressed;
    logic [1:0] present;
    logic snap_valid;
    logic snap_ack;
    logic overrun;

    modport master (
        output p1_buttons,
        output p2_buttons,
        output p1_pressed,
        output p2_pressed,
        output present,
        output snap_valid,
        output overrun,
        input snap_ack
    );

    modport slave (
        input p1_buttons,
        input p2_buttons,
        input p1_pressed,
        input p2_pressed,
        input present,
        input snap_valid,
        input overrun,
        output snap_ack
    );

endinterface

// File: rtl/gamepad_bit_mapper.sv
// Maps one port's 16 raw serial bits (low = pressed) onto
// the common 12-button word; an all-zero frame means no pad.
module gamepad_bit_mapper
    import gamepad_pkg::*;
(
    input logic [RAW_W-1:0] raw,
    input logic is_snes,
    output logic present,
    output logic [BTN_W-1:0] buttons
);

    // Decode by controller type, then blank an absent port
    always_comb begin
        buttons = '0;
        present = |raw;
        if (is_snes) begin
            buttons[BTN_B] = ~raw[0];
            buttons[BTN_Y] = ~raw[1];
            buttons[BTN_SELECT] = ~raw[2];
            buttons[BTN_START] = ~raw[3];
            buttons[BTN_UP] = ~raw[4];
            buttons[BTN_DOWN] = ~raw[5];
            buttons[BTN_LEFT] = ~raw[6];
            buttons[BTN_RIGHT] = ~raw[7];
            buttons[BTN_A] = ~raw[8];
            buttons[BTN_X] = ~raw[9];
            buttons[BTN_L] = ~raw[10];
            buttons[BTN_R] = ~raw[11];
        end else begin
            buttons[BTN_A] = ~raw[0];
            buttons[BTN_B] = ~raw[1];
            buttons[BTN_SELECT] = ~raw[2];
            buttons[BTN_START] = ~raw[3];
            buttons[BTN_UP] = ~raw[4];
            buttons[BTN_DOWN] = ~raw[5];
            buttons[BTN_LEFT] = ~raw[6];
            buttons[BTN_RIGHT] = ~raw[7];
        end
        if (!present) begin
            buttons = '0;
        end
    end

endmodule

// File: rtl/gamepad_poll_scheduler.sv
// Polls two (S)NES ports over a shared latch/clock pair and
// publishes a 12-button snapshot per player with valid/ack.
module gamepad_poll_scheduler
    import gamepad_pkg::*;
#(
    parameter int HALF_BIT = HALF_BIT_DEF,
    parameter int LATCH_CYC = LATCH_CYC_DEF,
    parameter int POLL_PERIOD = POLL_PERIOD_DEF,
    parameter int TMR_W = TMR_W_DEF
) (
    input logic clk_50,
    input logic reset,
    input logic poll_en,
    input logic frame_sync,
    input logic [1:0] is_snes,
    input logic [1:0] pad_data,
    output logic pad_latch,
    output logic pad_clk,
    output logic busy,
    gamepad_poll_scheduler_if.master snap
);

    localparam int BIT_CYC = 2 * HALF_BIT;
    localparam int CNT_MAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LEN = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] cyc_cnt;
    logic [3:0] bit_idx;
    logic [TMR_W-1:0] tmr;
    logic [1:0] snes_q;
    logic [RAW_W-1:0] raw1;
    logic [RAW_W-1:0] raw2;

    logic [BTN_W-1:0] btn1_q;
    logic [BTN_W-1:0] btn2_q;
    logic [BTN_W-1:0] btn1_nx;
    logic [BTN_W-1:0] btn2_nx;
    logic [1:0] pres_q;
    logic [1:0] pres_nx;
    logic valid_q;
    logic ovr_q;

    logic start;
    logic tmr_hit;
    logic latch_done;
    logic half_pt;
    logic bit_end;
    logic last_bit;
    logic commit;

    assign tmr_hit = (tmr == TMR_LAST);
    assign latch_done = (cyc_cnt == LATCH_LAST);
    assign half_pt = (cyc_cnt == HALF_LAST);
    assign bit_end = (cyc_cnt == BIT_LAST);
    assign last_bit = (bit_idx == 4'd15);
    assign commit = (state == COMMIT);

    // State register
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and poll start decision
    always_comb begin
        state_nx = state;
        start = 1'b0;
        unique case (state)
            IDLE: begin
                if (poll_en && (frame_sync || tmr_hit)) begin
                    start = 1'b1;
                    state_nx = LATCH;
                end
            end
            LATCH: begin
                if (latch_done) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_end && last_bit) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Phase cycle counter and bit index; both rest at 0 in IDLE
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                LATCH: begin
                    cyc_cnt <= latch_done ? '0 : cyc_cnt + CNT_W'(1);
                end
                SHIFT: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_idx <= bit_idx + 4'd1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // Fallback timer, saturating so a late IDLE still triggers
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            tmr <= '0;
        end else if (start || !poll_en) begin
            tmr <= '0;
        end else if (!tmr_hit) begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    // Controller type is frozen for the whole poll
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            snes_q <= '0;
        end else if (start) begin
            snes_q <= is_snes;
        end
    end

    // Sample both data lines just before pad_clk falls
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            raw1 <= '0;
            raw2 <= '0;
        end else if (state == SHIFT && half_pt) begin
            raw1[bit_idx] <= pad_data[0];
            raw2[bit_idx] <= pad_data[1];
        end
    end

    gamepad_bit_mapper u_map_p1 (
        .raw(raw1),
        .is_snes(snes_q[0]),
        .present(pres_nx[0]),
        .buttons(btn1_nx)
    );

    gamepad_bit_mapper u_map_p2 (
        .raw(raw2),
        .is_snes(snes_q[1]),
        .present(pres_nx[1]),
        .buttons(btn2_nx)
    );

    // Snapshot registers load at the end of COMMIT
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            btn1_q <= '0;
            btn2_q <= '0;
            pres_q <= '0;
        end else if (commit) begin
            btn1_q <= btn1_nx;
            btn2_q <= btn2_nx;
            pres_q <= pres_nx;
        end
    end

    // Handshake: a commit always wins over a same-cycle ack
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ovr_q <= 1'b0;
        end else if (commit) begin
            valid_q <= 1'b1;
            if (valid_q) begin
                ovr_q <= ~snap.snap_ack;
            end
        end else if (valid_q && snap.snap_ack) begin
            valid_q <= 1'b0;
            ovr_q <= 1'b0;
        end
    end

    assign pad_latch = (state == LATCH);
    assign pad_clk = !(state == SHIFT && cyc_cnt >= HALF_LEN);
    assign busy = (state != IDLE);

    assign snap.p1_buttons = btn1_q;
    assign snap.p2_buttons = btn2_q;
    assign snap.p1_pressed = commit ? (btn1_nx & ~btn1_q) : '0;
    assign snap.p2_pressed = commit ? (btn2_nx & ~btn2_q) : '0;
    assign snap.present = pres_q;
    assign snap.snap_valid = valid_q;
    assign snap.overrun = ovr_q;

endmodule
